// File: rtl/f_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : f_fetch_unit_if
//  Description : Bundle of the fetch-unit signals: hazard/redirect inputs,
//                instruction-memory request/response, and the F-stage
//                outputs toward the decode pipeline register.
//                master : the fetch unit's view (drives im_req/im_addr and
//                         the F outputs).
//                slave  : the surrounding environment (hazard unit, decode
//                         redirect logic, instruction memory).
//  Revision    : 1.0  initial release
// ============================================================================
interface f_fetch_unit_if;
   logic        stall;     // decode will not accept F outputs this cycle
   logic        npc_sel;   // branch/jump taken in decode
   logic [31:0] npc;       // redirect target, valid with npc_sel
   logic        im_req;    // instruction-memory read request
   logic [31:0] im_addr;   // instruction-memory read address
   logic        im_ready;  // memory returns data this cycle
   logic [31:0] im_rdata;  // instruction word, valid with im_ready
   logic [31:0] INSTR_F;   // fetched instruction (0 when not valid)
   logic [31:0] PC_F;      // address of INSTR_F
   logic [31:0] PC4_F;     // PC_F + 4
   logic        valid_F;   // F outputs hold a real instruction

   modport master (
      input  stall, npc_sel, npc, im_ready, im_rdata,
      output im_req, im_addr, INSTR_F, PC_F, PC4_F, valid_F
   );

   modport slave (
      output stall, npc_sel, npc, im_ready, im_rdata,
      input  im_req, im_addr, INSTR_F, PC_F, PC4_F, valid_F
   );
endinterface
`default_nettype wire

// File: rtl/f_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : f_fetch_unit
//  Description : Instruction fetch stage. Issues one instruction-memory read
//                at a time, holds the returned instruction toward decode
//                until it is consumed, and follows branch/jump redirects
//                with a one-instruction delay slot.
//  Ports       : clk    - clock, rising edge
//                reset  - synchronous, active-low
//                bus    - f_fetch_unit_if.master (hazard, redirect,
//                         instruction memory and F-stage outputs)
//  Revision    : 1.0  initial release
// ============================================================================
module f_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  wire logic        clk,
   input  wire logic        reset,
   f_fetch_unit_if.master   bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t      state_q,      state_d;
   logic [31:0] pc_q,         pc_d;
   logic        pend_valid_q, pend_valid_d;
   logic [31:0] pend_pc_q,    pend_pc_d;
   logic [31:0] instr_q,      instr_d;
   logic [31:0] pc_f_q,       pc_f_d;
   logic [31:0] pc4_f_q,      pc4_f_d;
   logic        valid_q,      valid_d;
   logic        im_req_q,     im_req_d;
   logic [31:0] im_addr_q,    im_addr_d;

   logic        w_redirect;
   logic [31:0] w_npc_aligned;
   logic [31:0] w_next_pc;

   // A redirect only counts when decode is actually advancing.
   assign w_redirect    = bus.npc_sel && !bus.stall;
   assign w_npc_aligned = bus.npc & 32'hFFFF_FFFC;

   // Address fetched after the held instruction is consumed: a redirect
   // arriving now beats one remembered from an earlier WAIT/IDLE cycle.
   always_comb begin
      w_next_pc = pc_q + 32'd4;
      if (w_redirect) begin
         w_next_pc = w_npc_aligned;
      end else if (pend_valid_q) begin
         w_next_pc = pend_pc_q;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pend_valid_d = pend_valid_q;
      pend_pc_d    = pend_pc_q;
      instr_d      = instr_q;
      pc_f_d       = pc_f_q;
      pc4_f_d      = pc4_f_q;
      valid_d      = valid_q;
      im_req_d     = im_req_q;
      im_addr_d    = im_addr_q;

      case (state_q)
         S_IDLE: begin
            // Redirect seen before the request is issued: the request
            // still goes out and becomes the delay slot.
            if (w_redirect) begin
               pend_valid_d = 1'b1;
               pend_pc_d    = w_npc_aligned;
            end
            state_d   = S_WAIT;
            im_req_d  = 1'b1;
            im_addr_d = pc_q;
         end

         S_WAIT: begin
            // Outstanding request's instruction is the delay slot; the
            // target is parked until that instruction is consumed.
            if (w_redirect) begin
               pend_valid_d = 1'b1;
               pend_pc_d    = w_npc_aligned;
            end
            if (bus.im_ready) begin
               instr_d  = bus.im_rdata;
               pc_f_d   = pc_q;
               pc4_f_d  = pc_q + 32'd4;
               valid_d  = 1'b1;
               im_req_d = 1'b0;
               state_d  = S_HOLD;
            end
         end

         S_HOLD: begin
            if (!bus.stall) begin
               pc_d         = w_next_pc;
               pend_valid_d = 1'b0;
               state_d      = S_WAIT;
               im_req_d     = 1'b1;
               im_addr_d    = w_next_pc;
               valid_d      = 1'b0;
               instr_d      = 32'd0;
            end
         end

         default: begin
            state_d  = S_IDLE;
            im_req_d = 1'b0;
            valid_d  = 1'b0;
            instr_d  = 32'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         pend_valid_q <= 1'b0;
         pend_pc_q    <= 32'd0;
         instr_q      <= 32'd0;
         pc_f_q       <= 32'd0;
         pc4_f_q      <= 32'd0;
         valid_q      <= 1'b0;
         im_req_q     <= 1'b0;
         im_addr_q    <= RESET_PC;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pend_valid_q <= pend_valid_d;
         pend_pc_q    <= pend_pc_d;
         instr_q      <= instr_d;
         pc_f_q       <= pc_f_d;
         pc4_f_q      <= pc4_f_d;
         valid_q      <= valid_d;
         im_req_q     <= im_req_d;
         im_addr_q    <= im_addr_d;
      end
   end

   // All outputs come straight from flops, so nothing on the memory
   // response side can reach im_req/im_addr combinationally.
   assign bus.im_req  = im_req_q;
   assign bus.im_addr = im_addr_q;
   assign bus.INSTR_F = instr_q;
   assign bus.PC_F    = pc_f_q;
   assign bus.PC4_F   = pc4_f_q;
   assign bus.valid_F = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_f_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_f_fetch_unit
//  Description : Self-checking bench for f_fetch_unit. Directed scenarios
//                followed by randomized stimulus, compared every cycle
//                against a transaction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_f_fetch_unit;

   localparam logic [31:0] C_RESET_PC = 32'h0000_3000;
   localparam int          C_IDLE     = 0;
   localparam int          C_WAIT     = 1;
   localparam int          C_HOLD     = 2;

   logic clk;
   logic reset;
   f_fetch_unit_if bus ();

   f_fetch_unit #(.RESET_PC(C_RESET_PC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   int          m_phase;
   logic [31:0] m_pc;
   bit          m_pend_v;
   logic [31:0] m_pend_pc;
   logic [31:0] m_pcf;
   logic [31:0] m_pc4f;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act,
                           input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Advance the model by one clock edge given the inputs applied to it.
   task automatic model_step(input bit rn, input bit st, input bit ns,
                             input logic [31:0] np, input bit rdy);
      bit take;
      take = ns && !st;
      if (!rn) begin
         m_phase   = C_IDLE;
         m_pc      = C_RESET_PC;
         m_pend_v  = 1'b0;
         m_pend_pc = 32'd0;
         m_pcf     = 32'd0;
         m_pc4f    = 32'd0;
      end else if (m_phase == C_IDLE || m_phase == C_WAIT) begin
         if (take) begin
            m_pend_v  = 1'b1;
            m_pend_pc = {np[31:2], 2'b00};
         end
         if (m_phase == C_IDLE) begin
            m_phase = C_WAIT;
         end else if (rdy) begin
            m_pcf   = m_pc;
            m_pc4f  = m_pc + 32'd4;
            m_phase = C_HOLD;
         end
      end else if (!st) begin
         if (take)          m_pc = {np[31:2], 2'b00};
         else if (m_pend_v) m_pc = m_pend_pc;
         else               m_pc = m_pc + 32'd4;
         m_pend_v = 1'b0;
         m_phase  = C_WAIT;
      end
   endtask

   task automatic cycle(input bit rn, input bit st, input bit ns,
                        input logic [31:0] np, input bit rdy);
      reset        = rn;
      bus.stall    = st;
      bus.npc_sel  = ns;
      bus.npc      = np;
      bus.im_ready = rdy;
      bus.im_rdata = rdy ? mem_word(bus.im_addr) : $urandom();
      @(posedge clk);
      model_step(rn, st, ns, np, rdy);
      #1;
      check_eq("im_req",  {31'd0, bus.im_req},  {31'd0, m_phase == C_WAIT});
      check_eq("valid_F", {31'd0, bus.valid_F}, {31'd0, m_phase == C_HOLD});
      check_eq("INSTR_F", bus.INSTR_F, (m_phase == C_HOLD) ? mem_word(m_pcf) : 32'd0);
      check_eq("PC_F",    bus.PC_F,    m_pcf);
      check_eq("PC4_F",   bus.PC4_F,   m_pc4f);
      if (m_phase != C_HOLD) check_eq("im_addr", bus.im_addr, m_pc);
   endtask

   initial begin
      reset        = 1'b0;
      bus.stall    = 1'b0;
      bus.npc_sel  = 1'b0;
      bus.npc      = 32'd0;
      bus.im_ready = 1'b0;
      bus.im_rdata = 32'd0;
      m_phase      = C_IDLE;
      m_pc         = C_RESET_PC;
      m_pend_v     = 1'b0;
      m_pend_pc    = 32'd0;
      m_pcf        = 32'd0;
      m_pc4f       = 32'd0;

      // reset state
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1);
      check_eq("rst_im_addr", bus.im_addr, 32'h0000_3000);

      // straight-line fetch, 1-cycle memory; im_ready in IDLE is ignored
      cycle(1, 0, 0, 0, 1);
      check_eq("seq_addr0", bus.im_addr, 32'h0000_3000);
      cycle(1, 0, 0, 0, 1);
      cycle(1, 0, 0, 0, 0);
      check_eq("seq_addr1", bus.im_addr, 32'h0000_3004);
      cycle(1, 0, 0, 0, 1);
      check_eq("hold_pc",   bus.PC_F,    32'h0000_3004);

      // stall in HOLD for 3 cycles; redirect during stall ignored
      for (int i = 0; i < 3; i++) cycle(1, 1, 1, 32'h0000_5000, 1);
      cycle(1, 0, 0, 0, 0);
      check_eq("after_stall_addr", bus.im_addr, 32'h0000_3008);

      // walk to HOLD at 0x3010
      cycle(1, 0, 0, 0, 1);
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 1);
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 1);
      check_eq("hold_3010", bus.PC_F, 32'h0000_3010);

      // delay-slot redirect from HOLD, aligned and misaligned targets
      cycle(1, 0, 1, 32'h0000_3100, 0);
      check_eq("redir_addr", bus.im_addr, 32'h0000_3100);
      cycle(1, 0, 0, 0, 1);
      cycle(1, 0, 1, 32'h0000_3103, 0);
      check_eq("redir_align", bus.im_addr, 32'h0000_3100);
      cycle(1, 0, 0, 0, 1);

      // redirect during WAIT for 0x3014 with slow memory
      cycle(1, 0, 1, 32'h0000_3014, 0);
      cycle(1, 0, 1, 32'h0000_3200, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 1);
      check_eq("slot_pc", bus.PC_F, 32'h0000_3014);
      cycle(1, 0, 0, 0, 0);
      check_eq("pend_addr", bus.im_addr, 32'h0000_3200);
      cycle(1, 0, 0, 0, 1);

      // wrap at top of address space
      cycle(1, 0, 1, 32'hFFFF_FFFC, 0);
      cycle(1, 0, 0, 0, 1);
      check_eq("top_pc4", bus.PC4_F, 32'h0000_0000);
      cycle(1, 0, 0, 0, 0);
      check_eq("wrap_addr", bus.im_addr, 32'h0000_0000);

      // reset in WAIT with a concurrent response
      cycle(0, 0, 0, 0, 1);
      check_eq("rst_wait_valid", {31'd0, bus.valid_F}, 32'd0);
      cycle(1, 0, 0, 0, 1);
      check_eq("rst_wait_addr", bus.im_addr, 32'h0000_3000);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 99) != 0),
               ($urandom_range(0, 99) < 40),
               ($urandom_range(0, 99) < 25),
               ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom(),
               ($urandom_range(0, 1) == 1));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/f_fetch_unit.md
F_FETCH_UNIT -- requirements
Module: f_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, address of the first instruction fetched after reset.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low; reset==0 at a rising edge resets the block.
REQ-004 stall  input  1  hold request from the hazard unit; 1 = decode stage will not accept the F outputs this cycle.
REQ-005 npc_sel  input  1  branch/jump taken, resolved in decode stage.
REQ-006 npc  input  32  redirect target, valid when npc_sel=1.
REQ-007 im_req  output  1  instruction-memory read request.
REQ-008 im_addr  output  32  instruction-memory read address.
REQ-009 im_ready  input  1  instruction memory returns data this cycle.
REQ-010 im_rdata  input  32  instruction word, valid when im_ready=1.
REQ-011 INSTR_F  output  32  fetched instruction to the decode pipeline register; 0 (nop) when valid_F=0.
REQ-012 PC_F  output  32  address of INSTR_F.
REQ-013 PC4_F  output  32  PC_F+4.
REQ-014 valid_F  output  1  INSTR_F/PC_F/PC4_F hold a real instruction.

Function
REQ-015 States: IDLE, WAIT, HOLD; internal regs: pc, pend_valid, pend_pc.
REQ-016 IDLE: im_req=0, valid_F=0; unconditionally -> WAIT next edge; im_ready ignored.
REQ-017 WAIT: im_req=1, im_addr=pc held stable until im_ready=1; valid_F=0, INSTR_F=0.
REQ-018 WAIT and im_ready=1: capture INSTR_F<=im_rdata, PC_F<=pc, PC4_F<=pc+4; -> HOLD; 1-cycle minimum memory latency.
REQ-019 HOLD: im_req=0, valid_F=1, outputs held constant while stall=1; im_ready ignored.
REQ-020 HOLD and stall=0: instruction consumed at this edge; pc<=next; -> WAIT; valid_F=0, INSTR_F=0 next cycle.
REQ-021 next = npc if (npc_sel=1 and stall=0); else pend_pc if pend_valid=1 (pend_valid<=0); else pc+4.
REQ-022 Delay slot: npc_sel=1 with stall=0 in HOLD means the held instruction is the delay slot; it is consumed, redirect applies to the following fetch.
REQ-023 npc_sel=1 with stall=0 in WAIT or IDLE: pend_valid<=1, pend_pc<=npc; outstanding request completes normally and its instruction is the delay slot.
REQ-024 npc_sel ignored whenever stall=1.
REQ-025 Second redirect while pend_valid=1 overwrites pend_pc (latest wins).
REQ-026 npc[1:0] forced to 2'b00 on capture; pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-027 No combinational path from im_rdata/im_ready to im_req/im_addr.

Reset
REQ-028 On reset: state=IDLE, pc=RESET_PC, pend_valid=0, pend_pc=0, INSTR_F=0, PC_F=0, PC4_F=0, valid_F=0, im_req=0, im_addr=RESET_PC.
REQ-029 Reset overrides every other input including mid-WAIT; im_req drops the following cycle; late im_ready after reset ignored.

Verification
REQ-030 Reset release, im_ready 1 cycle after each request, stall=0 -> im_addr 0x3000, 0x3004, 0x3008; valid_F every other cycle with PC_F matching, PC4_F=PC_F+4.
REQ-031 HOLD at PC 0x3004 with stall=1 for 3 cycles -> INSTR_F/PC_F constant, im_req=0, no new request; stall=0 -> next im_addr 0x3008.
REQ-032 HOLD at 0x3010, npc_sel=1, npc=0x3100, stall=0 -> next im_addr 0x3100; same with npc=0x3103 -> 0x3100.
REQ-033 Redirect npc=0x3200 during WAIT for 0x3014, im_ready delayed 3 cycles -> 0x3014 delivered as valid, then im_addr 0x3200.
REQ-034 Reset asserted in WAIT, im_ready=1 in reset cycle -> valid_F stays 0, next request at RESET_PC.
REQ-035 pc=0xFFFF_FFFC consumed, no redirect -> next im_addr 0x0000_0000.
